// File: rtl/cdb_writeback_arbiter.sv
// Common data bus write-back arbiter: grants one valid source per cycle and registers the broadcast.
// Optional build macro CDB_ROUND_ROBIN_EN selects rotating priority; otherwise fixed priority (ALU > LB > ACU).
module cdb_writeback_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       cdb_ready,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic [NUM_SRC-1:0]         src_written,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_SRC)-1:0] cdb_src,
    output logic [31:0]                cdb_count
);
    localparam int SRC_W = $clog2(NUM_SRC);

    // Handshake: a source's result is taken in the cycle src_written[i]=1, which requires
    // src_valid[i]=1 and cdb_ready=1 with no flush; an unaccepted source simply stays valid.
    logic               grant_en;
    logic               grant_hit;
    logic               grant;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand_idx;
    logic [TAG_W-1:0]   tag_arr  [NUM_SRC];
    logic [DATA_W-1:0]  data_arr [NUM_SRC];

`ifdef CDB_ROUND_ROBIN_EN
    logic [SRC_W-1:0]   rr_ptr;
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign tag_arr[g]  = src_tag[g*TAG_W +: TAG_W];
        assign data_arr[g] = src_data[g*DATA_W +: DATA_W];
    end

    assign grant_en = cdb_ready & ~flush;
    assign grant    = grant_hit & grant_en & reset_n;

    // First valid source in search order wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
            cand_idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
`else
            cand_idx = SRC_W'(k);
`endif
            if (!grant_hit && src_valid[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        src_written = '0;
        if (grant) begin
            src_written[grant_idx] = 1'b1;
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Backpressure (cdb_ready=0) keeps the current broadcast on the bus unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            cdb_count <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= tag_arr[grant_idx];
            cdb_data  <= data_arr[grant_idx];
            cdb_src   <= grant_idx;
            cdb_count <= cdb_count + 32'd1;
        end else if (cdb_ready) begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter; expectations follow CDB_ROUND_ROBIN_EN when defined.
module tb_cdb_writeback_arbiter;
  localparam int NUM_SRC = 3;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        cdb_ready;
  logic [2:0]  src_valid;
  logic [14:0] src_tag;
  logic [95:0] src_data;
  logic [2:0]  src_written;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [31:0] cdb_count;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_src;
  logic [31:0] exp_count;
  logic [2:0]  exp_onehot;

  cdb_writeback_arbiter #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .cdb_ready   (cdb_ready),
    .src_valid   (src_valid),
    .src_tag     (src_tag),
    .src_data    (src_data),
    .src_written (src_written),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src),
    .cdb_count   (cdb_count)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_src(input int i, input logic [4:0] t, input logic [31:0] d);
    src_tag[i*TAG_W +: TAG_W]    = t;
    src_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    src_valid = 3'b111;
    src_tag   = '0;
    src_data  = '0;
    #1;
    check("rst_written", src_written, 3'b000);
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_count", cdb_count, 32'd0);
    tick();
    tick();
    @(negedge clock);
    src_valid = 3'b000;
    reset_n   = 1'b1;
    tick();

    // single source on LB
    load_src(1, 5'd7, 32'hDEAD);
    src_valid = 3'b010;
    #1;
    check("single_written", src_written, 3'b010);
    tick();
    check("single_valid", cdb_valid, 1'b1);
    check("single_tag", cdb_tag, 5'd7);
    check("single_data", cdb_data, 32'hDEAD);
    check("single_src", cdb_src, 2'd1);
    check("single_count", cdb_count, 32'd1);
    src_valid = 3'b000;
    #1;
    check("idle_written", src_written, 3'b000);
    tick();
    check("idle_valid", cdb_valid, 1'b0);
    check("idle_tag_hold", cdb_tag, 5'd7);
    check("idle_count", cdb_count, 32'd1);

    // reset again so the rotation starts from source 0
    reset_n = 1'b0;
    #1;
    check("rerst_count", cdb_count, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // all sources valid for six cycles
    load_src(0, 5'd1, 32'h100);
    load_src(1, 5'd2, 32'h200);
    load_src(2, 5'd3, 32'h300);
    for (int k = 0; k < 6; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
      exp_q.push_back(2'(k % 3));
`else
      exp_q.push_back(2'd0);
`endif
    end
    src_valid = 3'b111;
    exp_count = 32'd0;
    exp_src   = 2'd0;
    for (int k = 0; k < 6; k++) begin
      exp_src    = exp_q.pop_front();
      exp_onehot = 3'b001 << exp_src;
      #1;
      check("all_written", src_written, exp_onehot);
      tick();
      exp_count = exp_count + 32'd1;
      check("all_valid", cdb_valid, 1'b1);
      check("all_src", cdb_src, exp_src);
      check("all_tag", cdb_tag, 5'(exp_src) + 5'd1);
      check("all_data", cdb_data, (32'(exp_src) + 32'd1) << 8);
      check("all_count", cdb_count, exp_count);
    end

    // backpressure holds the pending broadcast
    cdb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_written", src_written, 3'b000);
      tick();
      check("bp_valid", cdb_valid, 1'b1);
      check("bp_src", cdb_src, exp_src);
      check("bp_tag", cdb_tag, 5'(exp_src) + 5'd1);
      check("bp_count", cdb_count, 32'd6);
    end
    cdb_ready = 1'b1;
    #1;
    check("rel_written", src_written, 3'b001);
    tick();
    check("rel_valid", cdb_valid, 1'b1);
    check("rel_src", cdb_src, 2'd0);
    check("rel_count", cdb_count, 32'd7);

    // flush beats a grant
    src_valid = 3'b101;
    flush     = 1'b1;
    #1;
    check("fl_written", src_written, 3'b000);
    tick();
    check("fl_valid", cdb_valid, 1'b0);
    check("fl_count", cdb_count, 32'd7);
    flush = 1'b0;

    // deferred sources are still granted afterwards
    #1;
`ifdef CDB_ROUND_ROBIN_EN
    check("def_written", src_written, 3'b100);
`else
    check("def_written", src_written, 3'b001);
`endif
    tick();
    check("def_valid", cdb_valid, 1'b1);
    check("def_count", cdb_count, 32'd8);

    // counter wrap
    src_valid = 3'b000;
    force dut.cdb_count = 32'hFFFF_FFFF;
    #1;
    release dut.cdb_count;
    src_valid = 3'b010;
    #1;
    check("wrap_written", src_written, 3'b010);
    tick();
    check("wrap_count", cdb_count, 32'd0);
    check("wrap_valid", cdb_valid, 1'b1);

    // reset in the middle of a broadcast
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", cdb_valid, 1'b0);
    check("mid_rst_written", src_written, 3'b000);
    check("mid_rst_count", cdb_count, 32'd0);
    src_valid = 3'b000;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", cdb_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
